// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction fetch PC generator with 2-entry fetch FIFO; optional FETCH_MISALIGN_TRAP_EN halts on misaligned redirects
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch_flush,
    input  logic [31:0] i_branch_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_if_ready,
    output logic        o_misalign
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_DROP = 3'd2;
    localparam logic [2:0] S_FULL = 3'd3;

    logic [2:0]  state, state_n, resume;
    logic [31:0] pc, pc_n, tgt, tgt_r, tgt_n;
    logic [31:0] fifo_pc [2];
    logic [31:0] fifo_instr [2];
    logic        head, push, pop, busy, halted;
    logic [1:0]  count, count_n;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] S_HALT = 3'd4;
    logic bad, misalign, halt_pend;
    assign bad        = |i_branch_pc[1:0];
    assign tgt        = i_branch_pc;
    assign halted     = state == S_HALT;
    assign resume     = ((i_branch_flush & bad) | halt_pend) ? S_HALT : S_REQ;
    assign o_misalign = misalign;
    // Sticky trap flag, and a marker that the drop in flight must end in HALT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            misalign  <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            misalign  <= misalign | (i_branch_flush & bad);
            halt_pend <= (state_n == S_DROP) & (halt_pend | (i_branch_flush & bad));
        end
    end
`else
    assign tgt        = i_branch_pc & ~32'h3;
    assign halted     = 1'b0;
    assign resume     = S_REQ;
    assign o_misalign = 1'b0;
`endif

    assign busy        = (state == S_REQ) || (state == S_DROP);
    assign pop         = o_if_valid & i_if_ready;
    assign push        = (state == S_REQ) & i_imem_ack & ~i_branch_flush;
    assign count_n     = count + {1'b0, push} - {1'b0, pop};
    assign o_imem_req  = busy;
    assign o_imem_addr = pc;
    assign o_if_valid  = count != 2'd0;
    assign o_if_instr  = fifo_instr[head];
    assign o_if_pc     = fifo_pc[head];

    // Normal fetch progress first; a redirect then overrides it, but never moves an address mid-request
    always_comb begin
        state_n = state;
        pc_n    = pc;
        tgt_n   = tgt_r;
        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
                if (i_imem_ack) begin
                    state_n = (count_n == 2'd2) ? S_FULL : S_REQ;
                    pc_n    = pc + 32'd4;
                end
            end
            S_DROP: begin
                if (i_imem_ack) begin
                    state_n = resume;
                    pc_n    = tgt_r;
                end
            end
            S_FULL: state_n = pop ? S_REQ : S_FULL;
            default: ;
        endcase
        if (i_branch_flush && !halted) begin
            tgt_n = tgt;
            if (busy && !i_imem_ack) begin
                state_n = S_DROP;
                pc_n    = pc;
            end else begin
                state_n = resume;
                pc_n    = tgt;
            end
        end
    end

    // State, PC, redirect target and FIFO storage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            tgt_r         <= RESET_PC;
            head          <= 1'b0;
            count         <= 2'd0;
            fifo_pc[0]    <= 32'd0;
            fifo_pc[1]    <= 32'd0;
            fifo_instr[0] <= 32'd0;
            fifo_instr[1] <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            tgt_r <= tgt_n;
            count <= i_branch_flush ? 2'd0 : count_n;
            if (!i_branch_flush)
                head <= head ^ pop;
            if (push) begin
                fifo_pc[head ^ count[0]]    <= pc;
                fifo_instr[head ^ count[0]] <= i_imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: randomized and directed bench for fetch_pc_gen against a queue-based fetch-stream model
module tb_fetch_pc_gen;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        flush = 1'b0, ack = 1'b0, ready = 1'b0;
    logic [31:0] bpc = 32'd0, rdata = 32'd0;
    logic        imem_req, if_valid, misalign;
    logic [31:0] imem_addr, if_instr, if_pc;

    int tests = 0, fails = 0;

    logic [63:0] q[$];
    logic [31:0] m_addr, m_dtgt;
    bit          m_started, m_disc, m_halted, m_halt_after, m_mis;

    fetch_pc_gen #(.RESET_PC(RST_PC)) dut (
        .i_clk(clk), .i_rst(rst), .i_branch_flush(flush), .i_branch_pc(bpc),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc), .i_if_ready(ready),
        .o_misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mreq();
        return m_started && !m_halted && (m_disc || q.size() < 2);
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr = RST_PC; m_dtgt = RST_PC;
        m_started = 0; m_disc = 0; m_halted = 0; m_halt_after = 0; m_mis = 0;
    endtask

    task automatic model_step();
        logic [31:0] tg;
        bit bad, req;
        req = mreq();
        m_started = 1;
        if (m_halted) return;
`ifdef FETCH_MISALIGN_TRAP_EN
        tg = bpc;
        bad = bpc[1:0] != 2'b00;
`else
        tg = bpc & ~32'h3;
        bad = 0;
`endif
        if (flush) begin
            q.delete();
            if (bad) m_mis = 1;
            if (req && !ack) begin
                m_disc = 1;
                m_dtgt = tg;
                if (bad) m_halt_after = 1;
            end else begin
                m_addr = tg;
                m_disc = 0;
                if (bad || m_halt_after) m_halted = 1;
                m_halt_after = 0;
            end
        end else begin
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (req && ack) begin
                if (m_disc) begin
                    m_addr = m_dtgt;
                    m_disc = 0;
                    if (m_halt_after) m_halted = 1;
                    m_halt_after = 0;
                end else begin
                    q.push_back({m_addr, rdata});
                    m_addr = m_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("req", imem_req, mreq());
        if (mreq()) check("addr", imem_addr, m_addr);
        check("valid", if_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("if_pc", if_pc, q[0][63:32]);
            check("if_instr", if_instr, q[0][31:0]);
        end
        check("misalign", misalign, m_mis);
    endtask

    task automatic cycle(input bit f, input logic [31:0] b, input bit a, input bit r);
        @(negedge clk);
        compare_all();
        flush = f; bpc = b; ack = a; ready = r; rdata = $urandom;
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        flush = 1'b0; ack = 1'b0; ready = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_mis", misalign, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        bit f, a, r;
        logic [31:0] b;
        model_reset();
        // reset release, back-to-back fetch
        do_reset();
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 1);
            #1;
            check("stream_valid", if_valid, 1'b1);
            check("stream_pc", if_pc, 32'(k * 4));
        end
        // decode stall fills the FIFO
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
        #1;
        check("full_req", imem_req, 1'b0);
        check("full_head", if_pc, 32'h0);
        cycle(0, 0, 0, 1);
        #1;
        check("resume_head", if_pc, 32'h4);
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h8);
        cycle(0, 0, 0, 1);
        // redirect with request outstanding
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        cycle(1, 32'h100, 0, 1);
        #1;
        check("drop_addr", imem_addr, 32'h8);
        check("drop_valid", if_valid, 1'b0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        #1;
        check("drop_hold", imem_addr, 32'h8);
        cycle(0, 0, 1, 1);
        #1;
        check("drop_next", imem_addr, 32'h100);
        check("drop_empty", if_valid, 1'b0);
        cycle(0, 0, 1, 1);
        #1;
        check("drop_first_pc", if_pc, 32'h100);
        // redirect coinciding with ack and pop
        cycle(1, 32'h200, 1, 1);
        #1;
        check("same_valid", if_valid, 1'b0);
        check("same_addr", imem_addr, 32'h200);
        // address wrap
        cycle(1, 32'hFFFF_FFFC, 1, 1);
        cycle(0, 0, 1, 1);
        #1;
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        // reset mid-request, late ack ignored
        do_reset();
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 16; k++) cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        #1;
        check("mid_addr", imem_addr, 32'h40);
        do_reset();
        cycle(0, 0, 1, 1);
        #1;
        check("late_req", imem_req, 1'b1);
        check("late_addr", imem_addr, RST_PC);
        check("late_valid", if_valid, 1'b0);
        // misaligned redirect
        do_reset();
        cycle(1, 32'h102, 0, 1);
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", misalign, 1'b1);
        check("mis_req", imem_req, 1'b0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
        #1;
        check("mis_halt", imem_req, 1'b0);
`else
        check("mis_flag", misalign, 1'b0);
        check("mis_addr", imem_addr, 32'h100);
        check("mis_req", imem_req, 1'b1);
`endif
        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            f = $urandom_range(0, 15) == 0;
            b = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 9) == 0) b[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFF8;
            a = mreq() && ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9) < 7;
            cycle(f, b, a, r);
        end
        @(negedge clk);
        compare_all();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
